// File: rtl/udp_wrback_pkg.sv
// Shared types and helpers for the UDP write-back frame writer.
package udp_wrback_pkg;

  localparam int unsigned LEN_W     = 11;
  localparam logic [7:0]  HDR_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HDR,
    ST_DATA,
    ST_PAD,
    ST_DROP
  } state_e;

  // FIFO words occupied by a frame: one header word plus the padded payload.
  function automatic logic [LEN_W-1:0] calc_need(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] words;
    words = ({1'b0, len} + (LEN_W+1)'(3)) >> 2;
    return LEN_W'(words) + LEN_W'(1);
  endfunction

endpackage

// File: rtl/udp_wrback_byte_packer.sv
// Packs bytes big-endian into 32-bit words; a flush closes a partial word
// with zero padding in the low bytes.
module udp_wrback_byte_packer (
  input  logic        wclk,
  input  logic        wrst,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  input  logic        flush_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [23:0] acc_q;
  logic [1:0]  idx_q;
  logic [31:0] full_w;
  logic [4:0]  pad_sh;

  // Assemble the word that the current byte would complete.
  always_comb begin
    full_w       = {acc_q, byte_i};
    pad_sh       = {2'(2'd3 - idx_q), 3'b000};
    word_o       = full_w << pad_sh;
    word_valid_o = byte_valid_i & ((idx_q == 2'd3) | flush_i);
  end

  // Shift accepted bytes in; restart the word after every emit.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      acc_q <= '0;
      idx_q <= '0;
    end else if (byte_valid_i) begin
      if (word_valid_o) begin
        acc_q <= '0;
        idx_q <= '0;
      end else begin
        acc_q <= {acc_q[15:0], byte_i};
        idx_q <= idx_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/udp_wrback_frame_writer.sv
// Frames a UDP byte stream into header + payload words for the write-back
// FIFO, reserving FIFO space per frame so every frame is written whole.
module udp_wrback_frame_writer
  import udp_wrback_pkg::*;
#(
  parameter int unsigned c_WR_DEPTH_WIDTH = 9,
  parameter int unsigned c_MAX_LEN        = 1472
) (
  input  logic                        wclk,
  input  logic                        wrst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [7:0]                  s_data,
  input  logic                        s_last,
  input  logic [LEN_W-1:0]            s_len,
  output logic                        fifo_wr_en,
  output logic [31:0]                 fifo_wr_data,
  input  logic                        fifo_wfull,
  input  logic [c_WR_DEPTH_WIDTH:0]   fifo_wr_level,
  output logic [15:0]                 frm_cnt,
  output logic [15:0]                 drop_cnt,
  output logic                        err_len
);

  localparam int unsigned      CW        = c_WR_DEPTH_WIDTH + 2;
  localparam logic [CW-1:0]    DEPTH_W   = CW'(2**c_WR_DEPTH_WIDTH);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(c_MAX_LEN);

  state_e           state_q;
  logic [LEN_W-1:0] len_q, need_q, cnt_q, words_q;
  logic             wait_q, drop_idle_q;
  logic             wr_en_q, err_q;
  logic [31:0]      wr_data_q;
  logic [15:0]      frm_q, drop_q;

  logic [CW-1:0]    free_w, need_w;
  logic             room_ok, accept, flush;
  logic [LEN_W-1:0] cnt_d;
  logic             pk_emit;
  logic [31:0]      pk_word;

  // Reservation check against the write-side water level, plus byte handshake.
  always_comb begin
    free_w  = DEPTH_W - CW'(fifo_wr_level);
    need_w  = CW'(need_q);
    room_ok = (free_w >= need_w);
    case (state_q)
      ST_DATA: s_ready = ~fifo_wfull;
      ST_DROP: s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
    accept = s_valid & s_ready & (state_q == ST_DATA);
    cnt_d  = cnt_q + LEN_W'(1);
    flush  = s_last | (cnt_d == len_q);
  end

  udp_wrback_byte_packer u_packer (
    .wclk         (wclk),
    .wrst         (wrst),
    .byte_valid_i (accept),
    .byte_i       (s_data),
    .flush_i      (flush),
    .word_valid_o (pk_emit),
    .word_o       (pk_word)
  );

  // Frame FSM with registered FIFO write port, error pulse and counters.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      need_q      <= '0;
      cnt_q       <= '0;
      words_q     <= '0;
      wait_q      <= 1'b0;
      drop_idle_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      err_q       <= 1'b0;
      frm_q       <= '0;
      drop_q      <= '0;
    end else begin
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (s_valid) begin
            len_q  <= s_len;
            need_q <= calc_need(s_len);
            wait_q <= 1'b0;
            if ((s_len == '0) || (s_len > MAX_LEN_L)) begin
              drop_idle_q <= 1'b1;
              state_q     <= ST_DROP;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        // First WAIT cycle only lets the level settle; the compare is used from the second.
        ST_WAIT: begin
          if (!wait_q) begin
            wait_q <= 1'b1;
          end else if (room_ok) begin
            state_q <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (!fifo_wfull) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= {HDR_MAGIC, 13'b0, len_q};
            words_q   <= LEN_W'(1);
            cnt_q     <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept) begin
            cnt_q <= cnt_d;
            if (pk_emit) begin
              wr_en_q   <= 1'b1;
              wr_data_q <= pk_word;
              words_q   <= words_q + LEN_W'(1);
            end
            if (s_last) begin
              if (cnt_d == len_q) begin
                frm_q   <= frm_q + 16'd1;
                state_q <= ST_IDLE;
              end else begin
                err_q   <= 1'b1;
                state_q <= ST_PAD;
              end
            end else if (cnt_d == len_q) begin
              err_q       <= 1'b1;
              drop_idle_q <= 1'b0;
              state_q     <= ST_DROP;
            end
          end
        end
        // Short frame: the last flushed word may already complete the reservation.
        ST_PAD: begin
          if (!fifo_wfull) begin
            if (words_q == need_q) begin
              frm_q   <= frm_q + 16'd1;
              state_q <= ST_IDLE;
            end else begin
              wr_en_q   <= 1'b1;
              wr_data_q <= '0;
              words_q   <= words_q + LEN_W'(1);
            end
          end
        end
        ST_DROP: begin
          if (s_valid && s_last) begin
            if (drop_idle_q) drop_q <= drop_q + 16'd1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign frm_cnt      = frm_q;
  assign drop_cnt     = drop_q;
  assign err_len      = err_q;

endmodule

// File: tb/tb_udp_wrback_frame_writer.sv
// Self-checking bench for udp_wrback_frame_writer: directed frame table,
// level-reservation and full/reset sequences, and random frames against a
// frame-level reference model.
`timescale 1ns/1ps
module tb_udp_wrback_frame_writer;

  localparam int unsigned W     = 9;
  localparam int          MAXL  = 1472;
  localparam int          DEPTH = 512;

  logic        wclk = 1'b0;
  logic        wrst = 1'b1;
  logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [7:0]  s_data = '0;
  logic [10:0] s_len = '0;
  logic        fifo_wr_en, fifo_wfull = 1'b0, err_len;
  logic [31:0] fifo_wr_data;
  logic [W:0]  fifo_wr_level = '0;
  logic [15:0] frm_cnt, drop_cnt;

  int checks = 0, errors = 0;
  int exp_frm = 0, exp_drop = 0;
  bit abort = 1'b0;
  logic [7:0]  tx[$];
  logic [31:0] got[$], exp_q[$];
  int cyc = 0, last_wr = 0, max_gap = 0, err_seen = 0, wr_while_full = 0;
  logic full_d = 1'b0;

  typedef struct {
    string name;
    int    len;
    int    nbytes;
    int    exp_words;
    int    exp_err;
    int    exp_frm;
    int    exp_drop;
  } vec_t;
  vec_t vecs[$];

  always #5 wclk = ~wclk;

  udp_wrback_frame_writer #(.c_WR_DEPTH_WIDTH(W), .c_MAX_LEN(MAXL)) dut (
    .wclk          (wclk),
    .wrst          (wrst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_last        (s_last),
    .s_len         (s_len),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_wr_data  (fifo_wr_data),
    .fifo_wfull    (fifo_wfull),
    .fifo_wr_level (fifo_wr_level),
    .frm_cnt       (frm_cnt),
    .drop_cnt      (drop_cnt),
    .err_len       (err_len)
  );

  // FIFO-side monitor, sampled mid-cycle.
  always @(negedge wclk) begin
    cyc++;
    if (fifo_wr_en) begin
      if (got.size() > 0 && (cyc - last_wr) > max_gap) max_gap = cyc - last_wr;
      got.push_back(fifo_wr_data);
      last_wr = cyc;
      if (full_d) wr_while_full++;
    end
    if (err_len) err_seen++;
    full_d = fifo_wfull;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int i);
    if (i < got.size()) return got[i];
    return 32'hxxxxxxxx;
  endfunction

  // Reference model: header, then the first min(n,len) bytes laid big-endian
  // into ceil(len/4) zero-initialised words; bad lengths produce nothing.
  task automatic prep(input int len, input int n, input bit rnd,
                      output int ewords, output int eerr, output int finc, output int dinc);
    logic [31:0] w;
    tx.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) tx.push_back(rnd ? 8'($urandom) : 8'(i + 1));
    eerr = 0; finc = 0; dinc = 0;
    if (len == 0 || len > MAXL) begin
      dinc = 1;
    end else begin
      exp_q.push_back({8'hA5, 13'd0, 11'(len)});
      for (int wi = 0; wi < (len + 3) / 4; wi++) begin
        w = '0;
        for (int b = 0; b < 4; b++)
          if (4 * wi + b < n && 4 * wi + b < len) w[31 - 8 * b -: 8] = tx[4 * wi + b];
        exp_q.push_back(w);
      end
      eerr = (n != len) ? 1 : 0;
      finc = (n <= len) ? 1 : 0;
    end
    ewords = exp_q.size();
  endtask

  // Present tx[0..n-1] with optional bubbles; called and returns at posedge+1.
  task automatic send_frame(input int len, input int n, input int gap_pct, output int taken);
    int  i = 0, t = 0;
    bit  hs;
    taken = 0;
    while (i < n && !abort) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = tx[i];
        s_last  = (i == n - 1);
        s_len   = 11'(len);
      end
      @(negedge wclk);
      hs = s_valid && s_ready;
      @(posedge wclk); #1;
      if (hs) begin
        i++; taken++; t = 0;
      end else begin
        t++;
        if (t > 4000) begin
          checks++; errors++;
          $display("FAIL send: byte %0d of %0d not accepted within %0d cycles", i, n, t);
          break;
        end
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int quiet = 0, t = 0;
    while (quiet < 8) begin
      @(posedge wclk); #1;
      t++;
      if (fifo_wr_en) quiet = 0; else quiet++;
      if (t > 3000) begin
        checks++; errors++;
        $display("FAIL drain: FIFO writes still active after %0d cycles", t);
        break;
      end
    end
  endtask

  task automatic check_frame(input string nm, input int n, input int taken, input int e0,
                             input int ewords, input int eerr, input int finc, input int dinc);
    int bad = -1;
    exp_frm  = (exp_frm + finc) % 65536;
    exp_drop = (exp_drop + dinc) % 65536;
    chk({nm, " nwords"}, 64'(got.size()), 64'(ewords));
    if (exp_q.size() > 0) begin
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
        if (bad < 0 && got[i] !== exp_q[i]) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s word[%0d]: got %08h, expected %08h", nm, bad, got[bad], exp_q[bad]);
      end
    end
    chk({nm, " err_len pulses"}, 64'(err_seen - e0), 64'(eerr));
    chk({nm, " bytes consumed"}, 64'(taken), 64'(n));
    chk({nm, " frm_cnt"}, 64'(frm_cnt), 64'(exp_frm));
    chk({nm, " drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
  endtask

  task automatic go_frame(input string nm, input int len, input int n, input int gap,
                          input int ewords, input int eerr, input int finc, input int dinc);
    int taken, e0;
    got.delete();
    e0 = err_seen;
    send_frame(len, n, gap, taken);
    drain();
    check_frame(nm, n, taken, e0, ewords, eerr, finc, dinc);
  endtask

  initial begin
    int mw, me, mf, md, taken, e0, t;

    vecs.push_back('{"len5",    5,    5, 3, 0, 1, 0});
    vecs.push_back('{"len0",    0,    4, 0, 0, 0, 1});
    vecs.push_back('{"len1500", 1500, 4, 0, 0, 0, 1});
    vecs.push_back('{"short8",  8,    6, 3, 1, 1, 0});
    vecs.push_back('{"over4",   4,    7, 2, 1, 0, 0});
    vecs.push_back('{"len3",    3,    3, 2, 0, 1, 0});
    vecs.push_back('{"len1",    1,    1, 2, 0, 1, 0});
    vecs.push_back('{"len1473", 1473, 2, 0, 0, 0, 1});
    vecs.push_back('{"len4",    4,    4, 2, 0, 1, 0});
    vecs.push_back('{"over1",   1,    3, 2, 1, 0, 0});
    vecs.push_back('{"short9",  9,    1, 4, 1, 1, 0});

    // Reset state
    repeat (3) @(posedge wclk);
    #1;
    chk("rst s_ready", 64'(s_ready), 64'(0));
    chk("rst fifo_wr_en", 64'(fifo_wr_en), 64'(0));
    chk("rst fifo_wr_data", 64'(fifo_wr_data), 64'(0));
    chk("rst frm_cnt", 64'(frm_cnt), 64'(0));
    chk("rst drop_cnt", 64'(drop_cnt), 64'(0));
    chk("rst err_len", 64'(err_len), 64'(0));
    wrst = 1'b0;
    @(posedge wclk); #1;

    // Directed frame table
    foreach (vecs[i]) begin
      prep(vecs[i].len, vecs[i].nbytes, 1'b0, mw, me, mf, md);
      go_frame(vecs[i].name, vecs[i].len, vecs[i].nbytes, 0,
               vecs[i].exp_words, vecs[i].exp_err, vecs[i].exp_frm, vecs[i].exp_drop);
      if (i == 0) begin
        chk("len5 hdr", 64'(word_at(0)), 64'(32'hA5000005));
        chk("len5 w1", 64'(word_at(1)), 64'(32'h01020304));
        chk("len5 w2", 64'(word_at(2)), 64'(32'h05000000));
      end
      if (i == 3) begin
        chk("short8 hdr", 64'(word_at(0)), 64'(32'hA5000008));
        chk("short8 w2", 64'(word_at(2)), 64'(32'h05060000));
      end
    end

    // Reservation: 1472-byte frame held off until free space covers 369 words
    prep(1472, 1472, 1'b1, mw, me, mf, md);
    got.delete();
    e0 = err_seen;
    max_gap = 0;
    fifo_wr_level = (W+1)'(200);
    fork
      send_frame(1472, 1472, 0, taken);
      begin
        repeat (40) @(posedge wclk);
        #1;
        chk("lvl200 no write", 64'(got.size()), 64'(0));
        fifo_wr_level = (W+1)'(144);
        repeat (20) @(posedge wclk);
        #1;
        chk("lvl144 no write", 64'(got.size()), 64'(0));
        fifo_wr_level = (W+1)'(143);
      end
    join
    drain();
    check_frame("lvl1472", 1472, taken, e0, 369, 0, 1, 0);
    chk("lvl1472 max write gap", 64'(max_gap), 64'(4));
    fifo_wr_level = '0;

    // Random frames against the model
    for (int k = 0; k < 40; k++) begin
      int len, n, r, need, gap;
      r = int'($urandom_range(0, 9));
      if (r == 0) len = 0;
      else if (r == 1) len = int'($urandom_range(1473, 2047));
      else len = int'($urandom_range(1, 40));
      r = int'($urandom_range(0, 3));
      if (len == 0 || len > MAXL) n = int'($urandom_range(1, 6));
      else if (r == 1) n = len + int'($urandom_range(1, 5));
      else if (r == 2 && len > 1) n = int'($urandom_range(1, len - 1));
      else n = len;
      need = 1 + (len + 3) / 4;
      if (len == 0 || len > MAXL) fifo_wr_level = '0;
      else fifo_wr_level = (W+1)'($urandom_range(0, DEPTH - need));
      gap = int'($urandom_range(0, 30));
      prep(len, n, 1'b1, mw, me, mf, md);
      go_frame($sformatf("rnd%0d", k), len, n, gap, mw, me, mf, md);
    end
    fifo_wr_level = '0;

    // FIFO full mid-DATA, then asynchronous reset mid-frame
    prep(12, 12, 1'b0, mw, me, mf, md);
    got.delete();
    abort = 1'b0;
    fork
      send_frame(12, 12, 0, taken);
      begin
        t = 0;
        while (got.size() < 2 && t < 200) begin
          @(posedge wclk); #1;
          t++;
        end
        chk("wfull reached data", 64'(got.size() >= 2), 64'(1));
        fifo_wfull = 1'b1;
        wr_while_full = 0;
        repeat (6) begin
          @(negedge wclk);
          chk("wfull s_ready", 64'(s_ready), 64'(0));
        end
        @(posedge wclk); #1;
        chk("wfull writes while full", 64'(wr_while_full), 64'(0));
        #2;
        wrst = 1'b1;
        #1;
        chk("midrst s_ready", 64'(s_ready), 64'(0));
        chk("midrst fifo_wr_en", 64'(fifo_wr_en), 64'(0));
        chk("midrst fifo_wr_data", 64'(fifo_wr_data), 64'(0));
        chk("midrst frm_cnt", 64'(frm_cnt), 64'(0));
        chk("midrst drop_cnt", 64'(drop_cnt), 64'(0));
        chk("midrst err_len", 64'(err_len), 64'(0));
        abort = 1'b1;
        fifo_wfull = 1'b0;
        repeat (2) @(posedge wclk);
        #1;
        wrst = 1'b0;
      end
    join
    abort = 1'b0;
    exp_frm = 0;
    exp_drop = 0;
    @(posedge wclk); #1;

    // Clean frame after reset starts from IDLE with cleared counters
    prep(5, 5, 1'b0, mw, me, mf, md);
    go_frame("postrst", 5, 5, 0, 3, 0, 1, 0);
    chk("postrst hdr", 64'(word_at(0)), 64'(32'hA5000005));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_wrback_frame_writer.md
# udp_wrback_frame_writer

Write-side producer for the UDP write-back FIFO: packs a byte stream of framed UDP payloads into 32-bit words, prefixes each frame with a header word, and pushes the words into the FIFO write port. Before each frame it reserves FIFO space from the write-domain water level, so a frame is always written whole. It runs entirely in the FIFO write clock domain, between the UDP receive datapath and the FIFO controller/RAM.

## Interface
Parameters:
- c_WR_DEPTH_WIDTH, 9, FIFO write address width; depth = 2^c_WR_DEPTH_WIDTH words.
- c_MAX_LEN, 1472, largest legal frame length in bytes.

Ports:
- wclk  in  1  write-domain clock.
- wrst  in  1  reset, asynchronous, active-high.
- s_valid  in  1  input byte valid.
- s_ready  out  1  input byte accepted when s_valid & s_ready.
- s_data  in  8  payload byte.
- s_last  in  1  last byte of the frame.
- s_len  in  11  frame byte length; valid with the first byte of the frame.
- fifo_wr_en  out  1  FIFO write strobe, registered.
- fifo_wr_data  out  32  FIFO write word, registered.
- fifo_wfull  in  1  FIFO full flag.
- fifo_wr_level  in  c_WR_DEPTH_WIDTH+1  FIFO write water level in words.
- frm_cnt  out  16  frames written, wraps.
- drop_cnt  out  16  frames dropped, wraps.
- err_len  out  1  one-cycle pulse on a length mismatch.

## Operation
- Words per frame: need = 1 + ceil(s_len/4). Header = {8'hA5, 13'b0, s_len}. Payload is big-endian: the first byte goes to [31:24]. The last partial word is zero-padded.
- IDLE: s_ready=0. When s_valid is seen, latch s_len without consuming the byte.
  - If s_len==0 or s_len>c_MAX_LEN -> DROP.
  - Otherwise -> WAIT.
- WAIT: stay at least 2 cycles so the water level reflects the last writes. Then -> HDR once (2^c_WR_DEPTH_WIDTH - fifo_wr_level) >= need. Width rule: c_WR_DEPTH_WIDTH+2-bit unsigned compare.
- HDR: write the header word -> DATA.
- DATA: s_ready = ~fifo_wfull. Accepted bytes are shifted into the word. A word is written on the 4th byte or on s_last. The byte counter counts up to the latched length.
  - s_last with count==len -> IDLE, frm_cnt+1.
  - s_last with count<len: err_len, then -> PAD.
  - count==len without s_last: err_len, then -> DROP for the remainder.
- PAD: write zero words until the need words are done -> IDLE, frm_cnt+1.
- DROP: s_ready=1, discard bytes until s_last. On exit -> IDLE, drop_cnt+1, but only when entered from IDLE.
- fifo_wfull asserted in HDR/DATA/PAD: freeze the state, deassert s_ready, issue no write. This cannot occur with correct reservation; it is a stall only, never a loss.
- The number of FIFO words written per accepted frame is always exactly need.

## Timing
- Reset values: s_ready=0, fifo_wr_en=0, fifo_wr_data=0, frm_cnt=0, drop_cnt=0, err_len=0, state IDLE.
- s_ready is combinational from the state and fifo_wfull.
- fifo_wr_en/fifo_wr_data assert 1 cycle after the completing byte handshake. The header is written 1 cycle after WAIT is satisfied.
- Full-rate input gives 1 word per 4 cycles.
- Minimum frame overhead: 1 IDLE + 2 WAIT + 1 HDR cycles.
- Reset mid-frame: everything returns to its reset value at once, with no partial flush. The FIFO side is reset by the same wrst.
- Counters wrap 16'hFFFF -> 0.

## Structure
- Package udp_wrback_pkg:
  - header magic 8'hA5;
  - state enum IDLE/WAIT/HDR/DATA/PAD/DROP;
  - length width 11;
  - need-calculation function.
- Sub-module udp_wrback_byte_packer: 8->32 shift register with byte index, flush-on-last and zero padding.
- The FSM, reservation compare and counters sit in the top.

## Test plan
- Reset, then a 5-byte frame 01..05 with level 0. Required: words A5000005, 01020304, 05000000; frm_cnt=1.
- A 1472-byte frame with level 200 (free 312 < need 369). Required: no write until level ≤143, then 369 consecutive words, no stall.
- s_len=0 and s_len=1500 frames of 4 bytes. Required: no FIFO writes, 4 bytes consumed each, drop_cnt=2.
- s_len=8 with s_last on the 6th byte. Required: err_len pulse; words A5000008, b1..b4, {b5,b6,00,00}; frm_cnt=1.
- s_len=4 with 7 bytes sent. Required: words A5000004, b1..b4; err_len; 3 bytes dropped; next frame correct.
- fifo_wfull forced mid-DATA, then wrst asserted mid-frame. Required: s_ready=0 and no write while full; after reset all outputs are 0 and the FSM is in IDLE.
